// File: rtl/serial_tx_pkg.sv
// Shared types and arithmetic for the serial divisible-number transmitter.
// The state enum always includes PARITY. That state is reachable only when
// SERIAL_TX_PARITY_EN is defined.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Appends one bit to a remainder: (2*r + b) mod divisor.
  // Because r < divisor <= 16, the intermediate value is below 2*divisor.
  // A single conditional subtract therefore completes the reduction.
  function automatic logic [4:0] rem_step(input logic [3:0] r,
                                          input logic       b,
                                          input logic [4:0] divisor);
    logic [4:0] t;
    t = {r, b};
    return (t >= divisor) ? (t - divisor) : t;
  endfunction

endpackage

// File: rtl/serial_divisible_number_tx_mod_n_step.sv
// Combinational update of a remainder modulo DIVISOR for one appended bit.
// The serial divisibility receivers reuse the same step.
module mod_n_step
  import serial_tx_pkg::*;
#(
  parameter  int DIVISOR = 5,
  localparam int REM_W   = $clog2(DIVISOR)
) (
  input  logic [REM_W-1:0] rem_in,
  input  logic             bit_in,
  output logic [REM_W-1:0] rem_out
);

  assign rem_out = REM_W'(rem_step(4'(rem_in), bit_in, 5'(DIVISOR)));

endmodule

// File: rtl/serial_divisible_number_tx.sv
// Parallel-to-serial transmitter. It shifts a WIDTH-bit word out MSB-first.
// It also tracks the remainder of the emitted prefix modulo DIVISOR.
// Optional feature: define SERIAL_TX_PARITY_EN to append an even-parity bit.
module serial_divisible_number_tx
  import serial_tx_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int DIVISOR = 5,
  localparam int REM_W   = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_first,
  output logic             out_last,
  output logic [REM_W-1:0] rem,
  output logic             word_done,
  output logic [REM_W-1:0] result_rem,
  output logic             div_ok
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [CNT_W-1:0]   cnt;
  logic [REM_W-1:0]   rem_next;
  logic               last_bit;
  logic               handshake;

  mod_n_step #(.DIVISOR(DIVISOR)) u_step (
    .rem_in  (rem),
    .bit_in  (shreg[WIDTH-1]),
    .rem_out (rem_next)
  );

  assign last_bit  = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
  assign handshake = in_valid && in_ready;
  assign out_valid = (state != IDLE);
  assign out_first = (state == SHIFT) && (cnt == '0);

`ifdef SERIAL_TX_PARITY_EN
  logic par_q;

  assign in_ready = (state == IDLE) || (state == PARITY);
  assign out_bit  = (state == SHIFT)  ? shreg[WIDTH-1] :
                    (state == PARITY) ? par_q          : 1'b0;
  assign out_last = (state == PARITY);
`else
  assign in_ready = (state == IDLE) || last_bit;
  assign out_bit  = (state == SHIFT) && shreg[WIDTH-1];
  assign out_last = last_bit;
`endif

  // Runs the FSM, the datapath registers and the registered result outputs.
  // NOTE: all state uses non-blocking assignments, so every register samples
  // the values present before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      rem        <= '0;
      word_done  <= 1'b0;
      result_rem <= '0;
      div_ok     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            shreg <= in_data;
            cnt   <= '0;
            rem   <= '0;
            state <= SHIFT;
`ifdef SERIAL_TX_PARITY_EN
            par_q <= ^in_data;
`endif
          end
        end

        SHIFT: begin
          shreg <= shreg << 1;
          cnt   <= cnt + CNT_W'(1);
          rem   <= rem_next;
          if (last_bit) begin
            cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
            // rem keeps the whole-word remainder while the parity bit goes out.
            state <= PARITY;
`else
            result_rem <= rem_next;
            div_ok     <= (rem_next == '0);
            word_done  <= 1'b1;
            rem        <= '0;
            state      <= IDLE;
            if (handshake) begin
              shreg <= in_data;
              state <= SHIFT;
            end
`endif
          end
        end

        PARITY: begin
          result_rem <= rem;
          div_ok     <= (rem == '0);
          word_done  <= 1'b1;
          rem        <= '0;
          state      <= IDLE;
`ifdef SERIAL_TX_PARITY_EN
          if (handshake) begin
            shreg <= in_data;
            cnt   <= '0;
            state <= SHIFT;
            par_q <= ^in_data;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_divisible_number_tx.sv
// Self-checking bench for serial_divisible_number_tx with WIDTH=8 and DIVISOR=5.
// A word-level model predicts every output on every cycle.
// Directed literal sequences pin the model to known values.
module tb_serial_divisible_number_tx;

  localparam int WIDTH   = 8;
  localparam int DIVISOR = 5;
  localparam int REM_W   = $clog2(DIVISOR);
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = WIDTH + 1;
`else
  localparam int P = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_bit;
  logic             out_first;
  logic             out_last;
  logic [REM_W-1:0] rem;
  logic             word_done;
  logic [REM_W-1:0] result_rem;
  logic             div_ok;

  int n_checks = 0;
  int n_errors = 0;

  serial_divisible_number_tx #(.WIDTH(WIDTH), .DIVISOR(DIVISOR)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_bit    (out_bit),
    .out_first  (out_first),
    .out_last   (out_last),
    .rem        (rem),
    .word_done  (word_done),
    .result_rem (result_rem),
    .div_ok     (div_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: tracks the word being sent and the index of the bit on the line.
  logic        m_busy, m_done, m_ok, m_acc;
  int          m_idx;
  int unsigned m_word, m_res;
  logic        m_rdy, m_fin;

  assign m_rdy = !m_busy || (m_idx == P - 1);
  assign m_fin = m_busy && (m_idx == P - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_idx <= 0; m_word <= 0; m_done <= 1'b0;
      m_res  <= 0;    m_ok  <= 1'b1; m_acc <= 1'b0;
    end else begin
      m_acc  <= in_valid && m_rdy;
      m_done <= m_fin;
      if (m_fin) begin
        m_res <= m_word % DIVISOR;
        m_ok  <= (m_word % DIVISOR) == 0;
      end
      if (in_valid && m_rdy) begin
        m_busy <= 1'b1; m_idx <= 0; m_word <= in_data;
      end else if (m_fin) begin
        m_busy <= 1'b0;
      end else if (m_busy) begin
        m_idx <= m_idx + 1;
      end
    end
  end

  // Compares every output against the model on each falling edge while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      int unsigned e_bit, e_rem;
      e_bit = 0;
      e_rem = 0;
      if (m_busy) begin
        e_bit = (m_idx < WIDTH) ? ((m_word >> (WIDTH - 1 - m_idx)) & 1)
                                : ($countones(m_word) & 1);
        e_rem = (m_word >> (WIDTH - m_idx)) % DIVISOR;
      end
      check("in_ready",   64'(in_ready),   64'(m_rdy));
      check("out_valid",  64'(out_valid),  64'(m_busy));
      check("out_bit",    64'(out_bit),    64'(e_bit));
      check("out_first",  64'(out_first),  64'(m_busy && m_idx == 0));
      check("out_last",   64'(out_last),   64'(m_fin));
      check("rem",        64'(rem),        64'(e_rem));
      check("word_done",  64'(word_done),  64'(m_done));
      check("result_rem", 64'(result_rem), 64'(m_res));
      check("div_ok",     64'(div_ok),     64'(m_ok));
    end
  end

  // Holds in_valid until the model reports acceptance, with a bounded wait.
  task automatic send(input logic [WIDTH-1:0] v);
    int t;
    in_valid = 1'b1;
    in_data  = v;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!m_acc && t < 4 * P);
    if (!m_acc) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout value=%0d waited=%0d cycles", v, t);
    end
  endtask

  // Sends 25 and checks the literal bit, remainder and result sequence.
  // When inject is set, it also pulses in_valid mid-word.
  task automatic run_25(input bit inject);
    logic [7:0] bits;
    int         rem_lit [8];
    bits    = 8'b0001_1001;
    rem_lit = '{0, 0, 0, 0, 1, 3, 1, 2};
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd25;
    @(negedge clk);
    in_valid = 1'b0;
    check("d25_first", 64'(out_first), 64'd1);
    for (int k = 0; k < 8; k++) begin
      check("d25_bit", 64'(out_bit), 64'(bits[7-k]));
      check("d25_rem", 64'(rem), 64'(rem_lit[k]));
      if (inject && k == 3) begin
        in_valid = 1'b1; in_data = 8'hAA;
      end
      if (inject && k == 4) in_valid = 1'b0;
      @(negedge clk);
    end
`ifdef SERIAL_TX_PARITY_EN
    check("d25_par_bit",  64'(out_bit),  64'd1);
    check("d25_par_last", 64'(out_last), 64'd1);
    @(negedge clk);
`endif
    check("d25_done", 64'(word_done),  64'd1);
    check("d25_res",  64'(result_rem), 64'd0);
    check("d25_ok",   64'(div_ok),     64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(in_ready),   64'd1);
    check("rst_valid", 64'(out_valid),  64'd0);
    check("rst_res",   64'(result_rem), 64'd0);
    check("rst_ok",    64'(div_ok),     64'd1);

    // A single word, then the same word with an ignored mid-word pulse.
    run_25(1'b0);
    run_25(1'b1);

    // 26 then 255 back-to-back: a contiguous stream with no bubble.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd26;
    @(negedge clk);
    in_data = 8'd255;
    for (int c = 0; c < 2 * P; c++) begin
      check("b2b_valid", 64'(out_valid), 64'd1);
      if (c == P) begin
        in_valid = 1'b0;
        check("b2b_done1",  64'(word_done),  64'd1);
        check("b2b_res1",   64'(result_rem), 64'd1);
        check("b2b_ok1",    64'(div_ok),     64'd0);
        check("b2b_first2", 64'(out_first),  64'd1);
        check("b2b_rem2",   64'(rem),        64'd0);
      end
      @(negedge clk);
    end
    check("b2b_done2", 64'(word_done),  64'd1);
    check("b2b_res2",  64'(result_rem), 64'd0);
    check("b2b_ok2",   64'(div_ok),     64'd1);

`ifdef SERIAL_TX_PARITY_EN
    // Even parity of 0x0F is 0.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (WIDTH) @(negedge clk);
    check("par0f_bit",  64'(out_bit),  64'd0);
    check("par0f_last", 64'(out_last), 64'd1);
`endif

    // Leave a non-zero result, then reset in the middle of 25.
    send(8'd26);
    in_valid = 1'b0;
    repeat (P + 2) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd25;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(in_ready),   64'd1);
    check("arst_valid", 64'(out_valid),  64'd0);
    check("arst_bit",   64'(out_bit),    64'd0);
    check("arst_first", 64'(out_first),  64'd0);
    check("arst_last",  64'(out_last),   64'd0);
    check("arst_rem",   64'(rem),        64'd0);
    check("arst_done",  64'(word_done),  64'd0);
    check("arst_res",   64'(result_rem), 64'd0);
    check("arst_ok",    64'(div_ok),     64'd1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready),  64'd1);
    check("post_rst_done",  64'(word_done), 64'd0);
    run_25(1'b0);

    // All 256 words streamed back-to-back.
    for (int v = 0; v < 256; v++) send(WIDTH'(v));
    in_valid = 1'b0;
    repeat (P + 3) @(negedge clk);

    // Random traffic with random gaps in in_valid.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = WIDTH'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (P + 3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
